pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TMO, default 8'd200, meaning the IO-wait timeout in cycles before the error state.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 drs, drt  input  5 each  ID-stage source register numbers.
REQ-005 use_rs, use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-006 ewreg, em2reg  input  1 each  EX-stage register-write and load flags.
REQ-007 ern  input  5  EX-stage destination register.
REQ-008 mwreg, mm2reg  input  1 each  MEM-stage register-write and load flags.
REQ-009 mrn  input  5  MEM-stage destination register.
REQ-010 io_req  input  1  MEM-stage access targets IO space this cycle.
REQ-011 io_ready  input  1  IO device completes the access this cycle.
REQ-012 fwda, fwdb  output  2 each  operand select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data.
REQ-013 wpcir  output  1  1 = PC and IF/ID register advance.
REQ-014 bubble  output  1  1 = zero the controls entering ID/EX.
REQ-015 freeze  output  1  1 = hold ID/EX, EX/MEM and MEM/WB registers.
REQ-016 io_err  output  1  sticky IO timeout flag.
REQ-017 stall_cnt  output  16  count of cycles with wpcir=0.

Function
REQ-018 fwda SHALL be 01 if ewreg & ~em2reg & ern!=0 & ern==drs; else 10 if mwreg & ~mm2reg & mrn!=0 & mrn==drs; else 11 if mwreg & mm2reg & mrn!=0 & mrn==drs; else 00. fwdb SHALL follow the same rule using drt.
REQ-019 The EX-stage match SHALL have priority over the MEM-stage match. r0 SHALL never be forwarded.
REQ-020 A load-use hazard SHALL be defined as ewreg & em2reg & ern!=0 & ((use_rs & ern==drs) | (use_rt & ern==drt)).
REQ-021 FSM states (2-bit): RUN=0, IOWAIT=1, IOERR=2; encoding 3 SHALL go to RUN on the next cycle.
REQ-022 RUN state:
  - io_req & ~io_ready: freeze=1 combinationally in the same cycle; next state IOWAIT; wait counter loads 1.
  - io_req & io_ready: freeze=0; stay in RUN.
REQ-023 IOWAIT state: freeze=1.
  - io_ready=1: next state RUN; counter cleared.
  - otherwise, when counter==TMO: next state IOERR.
  - otherwise: counter increments.
REQ-024 IOERR state: freeze=1, io_err=1; the state is exited only by reset.
REQ-025 With freeze=0 and a load-use hazard: wpcir=0 and bubble=1 for exactly that cycle. No FSM state is needed; the hazard clears once the load moves to MEM.
REQ-026 With freeze=1: wpcir=0 and bubble=0 regardless of any hazard (the whole pipe holds). Forwarding outputs stay purely combinational.
REQ-027 Otherwise: wpcir=1, bubble=0.
REQ-028 stall_cnt SHALL increment on every clock edge where wpcir=0, and SHALL saturate at 16'hFFFF (no wrap).
REQ-029 The wait counter SHALL be 8 bits wide and SHALL be compared for equality with TMO; TMO=0 SHALL be treated as 1.

Reset
REQ-030 On reset=1 at a clock edge, the following SHALL be cleared: state=RUN, wait counter=0, io_err=0, stall_cnt=0. Reset SHALL override all other inputs, including mid-IOWAIT and in IOERR.
REQ-031 While the registered state is RUN after reset, the combinational outputs SHALL be wpcir=1, bubble=0, freeze=0 unless a hazard or io_req input is present.

Verification
REQ-032 ern=5, ewreg=1, em2reg=0, drs=5; mrn=5, mwreg=1 -> fwda=01 (EX priority). Same with ern=0 -> fwda=10.
REQ-033 ewreg=1, em2reg=1, ern=7, drt=7, use_rt=1 -> wpcir=0, bubble=1 for one cycle; stall_cnt 0->1. Same with use_rt=0 -> no stall.
REQ-034 io_req=1, io_ready=0 for 3 cycles, then io_ready=1 -> freeze=1 for 4 cycles, state back to RUN, bubble=0 throughout, stall_cnt=4.
REQ-035 TMO=4, io_req held with io_ready=0 -> IOERR entered after the counter reaches 4; io_err=1 held; reset -> io_err=0, state RUN.
REQ-036 Load-use hazard concurrent with IOWAIT -> bubble=0, wpcir=0. Force stall for 70000 cycles -> stall_cnt=FFFF and stays there.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, load-use stall and IO-wait freeze control for a 5-stage pipe
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   drs, drt, use_rs/rt   ID-stage source registers and whether they are read
//   ewreg, em2reg, ern    EX-stage write/load flags and destination
//   mwreg, mm2reg, mrn    MEM-stage write/load flags and destination
//   io_req, io_ready      MEM-stage IO access and device completion
//   fwda, fwdb            operand select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load
//   wpcir, bubble, freeze pipeline advance / ID-EX bubble / whole-pipe hold
//   io_err, stall_cnt     sticky IO timeout flag, saturating count of stalled cycles
module pipe_hazard_ctrl #(
    parameter logic [7:0] TMO = 8'd200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  drs,
    input  logic [4:0]  drt,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic [4:0]  mrn,
    input  logic        io_req,
    input  logic        io_ready,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        wpcir,
    output logic        bubble,
    output logic        freeze,
    output logic        io_err,
    output logic [15:0] stall_cnt
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] IOWAIT = 2'd1;
    localparam logic [1:0] IOERR  = 2'd2;
    localparam logic [7:0] TMO_EFF = (TMO == 8'd0) ? 8'd1 : TMO;
    logic [1:0] state, state_nx;
    logic [7:0] wcnt, wcnt_nx;
    logic       ex_a, ex_b, mem_a, mem_b, hazard;
    // EX alu results win over anything in MEM; loads still in EX cannot be forwarded
    assign ex_a  = ewreg & ~em2reg & (ern != 5'd0) & (ern == drs);
    assign ex_b  = ewreg & ~em2reg & (ern != 5'd0) & (ern == drt);
    assign mem_a = mwreg & (mrn != 5'd0) & (mrn == drs);
    assign mem_b = mwreg & (mrn != 5'd0) & (mrn == drt);
    assign fwda  = ex_a ? 2'b01 : mem_a ? {1'b1, mm2reg} : 2'b00;
    assign fwdb  = ex_b ? 2'b01 : mem_b ? {1'b1, mm2reg} : 2'b00;
    assign hazard = ewreg & em2reg & (ern != 5'd0) &
                    ((use_rs & (ern == drs)) | (use_rt & (ern == drt)));
    // freeze asserts in the very cycle an unready IO access appears
    assign freeze = (state == IOWAIT) | (state == IOERR) |
                    ((state == RUN) & io_req & ~io_ready);
    assign wpcir  = ~(freeze | hazard);
    assign bubble = ~freeze & hazard;
    assign io_err = state == IOERR;
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            RUN: if (io_req & ~io_ready) begin
                state_nx = IOWAIT;
                wcnt_nx  = 8'd1;
            end
            IOWAIT: if (io_ready) begin
                state_nx = RUN;
                wcnt_nx  = 8'd0;
            end else if (wcnt == TMO_EFF) begin
                state_nx = IOERR;
            end else begin
                wcnt_nx = wcnt + 8'd1;
            end
            IOERR: state_nx = IOERR;
            default: begin
                state_nx = RUN;
                wcnt_nx  = 8'd0;
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            wcnt      <= 8'd0;
            stall_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            wcnt      <= wcnt_nx;
            stall_cnt <= (~wpcir && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized and directed checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [4:0] drs, drt, ern, mrn;
    logic use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, io_req, io_ready;
    logic [1:0] fa [3];
    logic [1:0] fb [3];
    logic wp [3];
    logic bub [3];
    logic frz [3];
    logic err [3];
    logic [15:0] sc [3];
    int n_chk = 0;
    int n_fail = 0;
    // model: instance 0 default TMO, 1 TMO=4, 2 TMO=0 (acts as 1)
    int tmo_eff [3] = '{200, 4, 1};
    int m_wait [3];
    int m_err [3];
    int m_cnt [3];
    int m_stall [3];
    int e_fa, e_fb, e_hz;
    int e_frz [3];
    int e_wp [3];
    int e_bub [3];

    always #5 clock = ~clock;

    pipe_hazard_ctrl u_def (.clock(clock), .reset(reset), .drs(drs), .drt(drt), .use_rs(use_rs),
        .use_rt(use_rt), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg),
        .mrn(mrn), .io_req(io_req), .io_ready(io_ready), .fwda(fa[0]), .fwdb(fb[0]), .wpcir(wp[0]),
        .bubble(bub[0]), .freeze(frz[0]), .io_err(err[0]), .stall_cnt(sc[0]));
    pipe_hazard_ctrl #(.TMO(8'd4)) u_t4 (.clock(clock), .reset(reset), .drs(drs), .drt(drt), .use_rs(use_rs),
        .use_rt(use_rt), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg),
        .mrn(mrn), .io_req(io_req), .io_ready(io_ready), .fwda(fa[1]), .fwdb(fb[1]), .wpcir(wp[1]),
        .bubble(bub[1]), .freeze(frz[1]), .io_err(err[1]), .stall_cnt(sc[1]));
    pipe_hazard_ctrl #(.TMO(8'd0)) u_t0 (.clock(clock), .reset(reset), .drs(drs), .drt(drt), .use_rs(use_rs),
        .use_rt(use_rt), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg),
        .mrn(mrn), .io_req(io_req), .io_ready(io_ready), .fwda(fa[2]), .fwdb(fb[2]), .wpcir(wp[2]),
        .bubble(bub[2]), .freeze(frz[2]), .io_err(err[2]), .stall_cnt(sc[2]));

    function automatic int fwd_ref(input logic [4:0] d);
        if (ewreg && !em2reg && ern != 0 && ern == d) return 1;
        if (mwreg && mrn != 0 && mrn == d) return mm2reg ? 3 : 2;
        return 0;
    endfunction

    task automatic eval_model();
        e_fa = fwd_ref(drs);
        e_fb = fwd_ref(drt);
        e_hz = (ewreg && em2reg && ern != 0 && ((use_rs && ern == drs) || (use_rt && ern == drt))) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            e_frz[i] = (m_err[i] != 0 || m_wait[i] != 0 || (io_req && !io_ready)) ? 1 : 0;
            e_wp[i]  = (e_frz[i] != 0 || e_hz != 0) ? 0 : 1;
            e_bub[i] = (e_frz[i] == 0 && e_hz != 0) ? 1 : 0;
        end
    endtask

    task automatic step();
        eval_model();
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_wait[i] = 0; m_err[i] = 0; m_cnt[i] = 0; m_stall[i] = 0;
            end else begin
                if (e_wp[i] == 0 && m_stall[i] < 65535) m_stall[i]++;
                if (m_err[i] != 0) begin
                end else if (m_wait[i] != 0) begin
                    if (io_ready) begin m_wait[i] = 0; m_cnt[i] = 0; end
                    else if (m_cnt[i] == tmo_eff[i]) begin m_err[i] = 1; m_wait[i] = 0; end
                    else m_cnt[i]++;
                end else if (io_req && !io_ready) begin
                    m_wait[i] = 1; m_cnt[i] = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        drs = 0; drt = 0; ern = 0; mrn = 0;
        use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
        io_req = 0; io_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1; step(); step(); reset = 0;
    endtask

    task automatic rnd_pipe();
        drs = 5'($urandom_range(0, 3)); drt = 5'($urandom_range(0, 3));
        ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
        use_rs = 1'($urandom); use_rt = 1'($urandom);
        ewreg = 1'($urandom); em2reg = 1'($urandom);
        mwreg = 1'($urandom); mm2reg = 1'($urandom);
    endtask

    task automatic test_reset();
        idle();
        io_req = 1; ewreg = 1; em2reg = 1; ern = 3; drs = 3; use_rs = 1;
        reset = 1; step(); step(); reset = 0;
        idle();
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            if (wp[i] !== 1'b1) begin n_fail++; $display("FAIL reset_wpcir[%0d]: got %b want 1", i, wp[i]); end
            if (bub[i] !== 1'b0) begin n_fail++; $display("FAIL reset_bubble[%0d]: got %b want 0", i, bub[i]); end
            if (frz[i] !== 1'b0) begin n_fail++; $display("FAIL reset_freeze[%0d]: got %b want 0", i, frz[i]); end
            if (err[i] !== 1'b0) begin n_fail++; $display("FAIL reset_io_err[%0d]: got %b want 0", i, err[i]); end
            if (sc[i] !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt[%0d]: got %0h want 0", i, sc[i]); end
            n_chk += 5;
        end
        step();
    endtask

    task automatic test_forward();
        do_reset();
        ewreg = 1; em2reg = 0; ern = 5; drs = 5; mwreg = 1; mm2reg = 0; mrn = 5;
        @(negedge clock);
        if (fa[0] !== 2'b01) begin n_fail++; $display("FAIL fwd_ex_priority: got %b want 01", fa[0]); end
        ern = 0; #1;
        if (fa[0] !== 2'b10) begin n_fail++; $display("FAIL fwd_r0_ex_mem_alu: got %b want 10", fa[0]); end
        mm2reg = 1; #1;
        if (fa[0] !== 2'b11) begin n_fail++; $display("FAIL fwd_mem_load: got %b want 11", fa[0]); end
        mrn = 0; #1;
        if (fa[0] !== 2'b00) begin n_fail++; $display("FAIL fwd_r0_never: got %b want 00", fa[0]); end
        n_chk += 4;
        step();
        for (int k = 0; k < 300; k++) begin
            rnd_pipe();
            @(negedge clock);
            eval_model();
            if (fa[0] !== 2'(e_fa)) begin n_fail++; $display("FAIL fwd_rand_a: got %b want %0d", fa[0], e_fa); end
            if (fb[0] !== 2'(e_fb)) begin n_fail++; $display("FAIL fwd_rand_b: got %b want %0d", fb[0], e_fb); end
            if (wp[0] !== 1'(e_wp[0])) begin n_fail++; $display("FAIL fwd_rand_wpcir: got %b want %0d", wp[0], e_wp[0]); end
            n_chk += 3;
            step();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ewreg = 1; em2reg = 1; ern = 7; drt = 7; use_rt = 1;
        @(negedge clock);
        if (wp[0] !== 1'b0) begin n_fail++; $display("FAIL lu_wpcir: got %b want 0", wp[0]); end
        if (bub[0] !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b want 1", bub[0]); end
        if (sc[0] !== 16'd0) begin n_fail++; $display("FAIL lu_cnt_before: got %0h want 0", sc[0]); end
        n_chk += 3;
        step();
        ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mm2reg = 1; mrn = 7;
        @(negedge clock);
        if (wp[0] !== 1'b1) begin n_fail++; $display("FAIL lu_clear_wpcir: got %b want 1", wp[0]); end
        if (bub[0] !== 1'b0) begin n_fail++; $display("FAIL lu_clear_bubble: got %b want 0", bub[0]); end
        if (sc[0] !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_after: got %0h want 1", sc[0]); end
        if (fb[0] !== 2'b11) begin n_fail++; $display("FAIL lu_fwd_load: got %b want 11", fb[0]); end
        n_chk += 4;
        step();
        idle(); ewreg = 1; em2reg = 1; ern = 7; drt = 7; use_rt = 0;
        @(negedge clock);
        if (wp[0] !== 1'b1) begin n_fail++; $display("FAIL lu_unused_wpcir: got %b want 1", wp[0]); end
        if (bub[0] !== 1'b0) begin n_fail++; $display("FAIL lu_unused_bubble: got %b want 0", bub[0]); end
        n_chk += 2;
        step();
        @(negedge clock);
        if (sc[0] !== 16'd1) begin n_fail++; $display("FAIL lu_unused_cnt: got %0h want 1", sc[0]); end
        n_chk++;
        step();
    endtask

    task automatic test_io_wait();
        do_reset();
        io_req = 1; io_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (frz[0] !== 1'b1) begin n_fail++; $display("FAIL iow_freeze[%0d]: got %b want 1", k, frz[0]); end
            if (bub[0] !== 1'b0) begin n_fail++; $display("FAIL iow_bubble[%0d]: got %b want 0", k, bub[0]); end
            n_chk += 2;
            step();
        end
        io_ready = 1;
        @(negedge clock);
        if (frz[0] !== 1'b1) begin n_fail++; $display("FAIL iow_freeze_ready: got %b want 1", frz[0]); end
        n_chk++;
        step();
        idle();
        @(negedge clock);
        if (frz[0] !== 1'b0) begin n_fail++; $display("FAIL iow_back_run_freeze: got %b want 0", frz[0]); end
        if (wp[0] !== 1'b1) begin n_fail++; $display("FAIL iow_back_run_wpcir: got %b want 1", wp[0]); end
        if (sc[0] !== 16'd4) begin n_fail++; $display("FAIL iow_stall_cnt: got %0h want 4", sc[0]); end
        n_chk += 3;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        io_req = 1; io_ready = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            eval_model();
            for (int i = 1; i < 3; i++) begin
                if (err[i] !== 1'(m_err[i])) begin n_fail++; $display("FAIL tmo_io_err[%0d] cyc %0d: got %b want %0d", i, k, err[i], m_err[i]); end
                if (frz[i] !== 1'b1) begin n_fail++; $display("FAIL tmo_freeze[%0d] cyc %0d: got %b want 1", i, k, frz[i]); end
                n_chk += 2;
            end
            step();
        end
        io_ready = 1;
        step();
        @(negedge clock);
        if (err[1] !== 1'b1) begin n_fail++; $display("FAIL tmo4_sticky: got %b want 1", err[1]); end
        if (err[2] !== 1'b1) begin n_fail++; $display("FAIL tmo0_sticky: got %b want 1", err[2]); end
        if (err[0] !== 1'b0) begin n_fail++; $display("FAIL tmo200_no_err: got %b want 0", err[0]); end
        n_chk += 3;
        io_ready = 0;
        reset = 1; step(); reset = 0;
        idle();
        @(negedge clock);
        if (err[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_reset_err: got %b want 0", err[1]); end
        if (frz[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_reset_freeze: got %b want 0", frz[1]); end
        if (sc[1] !== 16'd0) begin n_fail++; $display("FAIL tmo_reset_cnt: got %0h want 0", sc[1]); end
        n_chk += 3;
        step();
    endtask

    task automatic test_hazard_in_iowait();
        do_reset();
        io_req = 1; io_ready = 0; ewreg = 1; em2reg = 1; ern = 9; drs = 9; use_rs = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (bub[0] !== 1'b0) begin n_fail++; $display("FAIL hz_io_bubble[%0d]: got %b want 0", k, bub[0]); end
            if (wp[0] !== 1'b0) begin n_fail++; $display("FAIL hz_io_wpcir[%0d]: got %b want 0", k, wp[0]); end
            n_chk += 2;
            step();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rnd_pipe();
            io_req = ($urandom_range(0, 3) == 0);
            io_ready = 1'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            @(negedge clock);
            eval_model();
            for (int i = 0; i < 3; i++) begin
                if (fa[i] !== 2'(e_fa) || fb[i] !== 2'(e_fb)) begin
                    n_fail++; $display("FAIL rand_fwd[%0d]: got %b/%b want %0d/%0d", i, fa[i], fb[i], e_fa, e_fb);
                end
                if (wp[i] !== 1'(e_wp[i]) || bub[i] !== 1'(e_bub[i]) || frz[i] !== 1'(e_frz[i])) begin
                    n_fail++; $display("FAIL rand_ctl[%0d]: got wp%b bub%b frz%b want wp%0d bub%0d frz%0d",
                        i, wp[i], bub[i], frz[i], e_wp[i], e_bub[i], e_frz[i]);
                end
                if (err[i] !== 1'(m_err[i]) || sc[i] !== 16'(m_stall[i])) begin
                    n_fail++; $display("FAIL rand_state[%0d]: got err%b cnt%0h want err%0d cnt%0h", i, err[i], sc[i], m_err[i], m_stall[i]);
                end
                n_chk += 3;
            end
            step();
        end
        reset = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        io_req = 1; io_ready = 0;
        repeat (70000) step();
        for (int r = 0; r < 2; r++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                if (sc[i] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt[%0d] pass %0d: got %0h want ffff", i, r, sc[i]); end
                n_chk++;
            end
            repeat (5) step();
        end
    endtask

    initial begin
        idle();
        m_wait = '{0, 0, 0}; m_err = '{0, 0, 0}; m_cnt = '{0, 0, 0}; m_stall = '{0, 0, 0};
        test_reset();
        test_forward();
        test_load_use();
        test_io_wait();
        test_timeout();
        test_hazard_in_iowait();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
